// File: rtl/ov7670_sccb_sequencer_if.sv
// ov7670_sccb_sequencer_if
// Request/response bus between the OV7670 configuration sequencer and the
// SCCB byte master.
//   oSCCB_GO     sequencer -> master  transaction request (level, held until END)
//   oSCCB_RD     sequencer -> master  1 = read transaction, 0 = write
//   oSCCB_DATA   sequencer -> master  {device id, register, data}
//   iSCCB_END    master -> sequencer  one-cycle pulse, transaction complete
//   iSCCB_NACK   master -> sequencer  valid with END, 1 = slave did not ack
//   iSCCB_RDATA  master -> sequencer  read byte, valid with END
interface ov7670_sccb_sequencer_if;
    logic        oSCCB_GO;
    logic        oSCCB_RD;
    logic [23:0] oSCCB_DATA;
    logic        iSCCB_END;
    logic        iSCCB_NACK;
    logic [7:0]  iSCCB_RDATA;

    // Sequencer side issues requests and consumes completions.
    modport master (
        output oSCCB_GO, oSCCB_RD, oSCCB_DATA,
        input  iSCCB_END, iSCCB_NACK, iSCCB_RDATA
    );

    // SCCB byte master side.
    modport slave (
        input  oSCCB_GO, oSCCB_RD, oSCCB_DATA,
        output iSCCB_END, iSCCB_NACK, iSCCB_RDATA
    );
endinterface

// File: rtl/ov7670_sccb_sequencer.sv
// ov7670_sccb_sequencer
// Walks the OV7670 configuration LUT from index 0 to LUT_SIZE-1 and issues one
// SCCB transaction per entry. The first READ_ENTRIES entries are ID read-backs
// compared against the LUT data byte; the rest are register writes. Handles the
// power-up wait, the wait after a COM7 soft reset, NACK retry and re-runs on
// request.
// Ports:
//   iCLK, iRST        clock, asynchronous active-high reset
//   iRECONFIG         one-cycle restart pulse, honoured in DONE or ERROR only
//   oLUT_INDEX        LUT address
//   iLUT_DATA         LUT entry {reg, data}, combinational from oLUT_INDEX
//   sccb              request/response bus to the SCCB byte master
//   oCONFIG_DONE      all entries completed
//   oID_OK            every ID read-back matched (valid in DONE)
//   oERROR            retry budget exhausted, oLUT_INDEX holds failing entry
module ov7670_sccb_sequencer #(
    parameter int         POWERUP_WAIT = 1_000_000,
    parameter int         RESET_WAIT   = 50_000,
    parameter int         LUT_SIZE     = 167,
    parameter int         READ_ENTRIES = 2,
    parameter logic [7:0] SCCB_ID      = 8'h42,
    parameter int         MAX_RETRY    = 3
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           iRECONFIG,
    output logic [7:0]                     oLUT_INDEX,
    input  logic [15:0]                    iLUT_DATA,
    ov7670_sccb_sequencer_if.master        sccb,
    output logic                           oCONFIG_DONE,
    output logic                           oID_OK,
    output logic                           oERROR
);

    localparam int MAX_WAIT = (POWERUP_WAIT > RESET_WAIT) ? POWERUP_WAIT : RESET_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        FETCH,
        ISSUE,
        WAIT_END,
        CHECK,
        DELAY,
        DONE,
        ERROR
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   waitCnt_q;
    logic [7:0]         index_q;
    logic [RTY_W-1:0]   retry_q;
    logic [15:0]        entry_q;
    logic               go_q;
    logic               rd_q;
    logic [23:0]        data_q;
    logic               nack_q;
    logic [7:0]         rdata_q;
    logic               idOkFlag_q;
    logic               done_q;
    logic               idOk_q;
    logic               error_q;

    logic               isRead;
    logic               lastEntry;
    logic               softReset;
    logic               idOkFlag_d;

    assign isRead     = (index_q < 8'(READ_ENTRIES));
    assign lastEntry  = (index_q == 8'(LUT_SIZE - 1));
    // A write of COM7 (0x12) with bit7 set resets the sensor, which then needs
    // time before it accepts further register writes.
    assign softReset  = !isRead && (entry_q[15:8] == 8'h12) && entry_q[7];
    // A read-back mismatch clears the flag but never stops the sequence.
    assign idOkFlag_d = idOkFlag_q & ~(isRead & (rdata_q != entry_q[7:0]));

    // Main sequencer: every output is a register so the SCCB master and the
    // LUT see glitch-free levels. GO is raised when leaving ISSUE and dropped
    // on the END pulse, so a stray END while GO is low is never observed
    // outside WAIT_END.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= PWR_WAIT;
            waitCnt_q  <= '0;
            index_q    <= '0;
            retry_q    <= '0;
            entry_q    <= '0;
            go_q       <= 1'b0;
            rd_q       <= 1'b0;
            data_q     <= '0;
            nack_q     <= 1'b0;
            rdata_q    <= '0;
            idOkFlag_q <= 1'b0;
            done_q     <= 1'b0;
            idOk_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    index_q    <= '0;
                    retry_q    <= '0;
                    error_q    <= 1'b0;
                    idOkFlag_q <= 1'b1;
                    if (waitCnt_q == CNT_W'(POWERUP_WAIT - 1)) begin
                        waitCnt_q <= '0;
                        state_q   <= FETCH;
                    end else begin
                        waitCnt_q <= waitCnt_q + CNT_W'(1);
                    end
                end

                FETCH: begin
                    entry_q <= iLUT_DATA;
                    state_q <= ISSUE;
                end

                ISSUE: begin
                    go_q    <= 1'b1;
                    rd_q    <= isRead;
                    data_q  <= {SCCB_ID, entry_q[15:8], isRead ? 8'h00 : entry_q[7:0]};
                    state_q <= WAIT_END;
                end

                WAIT_END: begin
                    if (sccb.iSCCB_END) begin
                        nack_q  <= sccb.iSCCB_NACK;
                        rdata_q <= sccb.iSCCB_RDATA;
                        go_q    <= 1'b0;
                        state_q <= CHECK;
                    end
                end

                CHECK: begin
                    if (nack_q) begin
                        // Retry re-issues the same latched entry; index unchanged.
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_q <= retry_q + RTY_W'(1);
                            state_q <= ISSUE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= ERROR;
                        end
                    end else begin
                        idOkFlag_q <= idOkFlag_d;
                        retry_q    <= '0;
                        if (softReset) begin
                            waitCnt_q <= '0;
                            state_q   <= DELAY;
                        end else if (lastEntry) begin
                            done_q  <= 1'b1;
                            idOk_q  <= idOkFlag_d;
                            state_q <= DONE;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= FETCH;
                        end
                    end
                end

                DELAY: begin
                    if (waitCnt_q == CNT_W'(RESET_WAIT - 1)) begin
                        waitCnt_q <= '0;
                        if (lastEntry) begin
                            done_q  <= 1'b1;
                            idOk_q  <= idOkFlag_q;
                            state_q <= DONE;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= FETCH;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + CNT_W'(1);
                    end
                end

                DONE, ERROR: begin
                    // Re-run skips the power-up wait: the sensor is already up.
                    if (iRECONFIG) begin
                        index_q    <= '0;
                        retry_q    <= '0;
                        idOkFlag_q <= 1'b1;
                        done_q     <= 1'b0;
                        idOk_q     <= 1'b0;
                        error_q    <= 1'b0;
                        rd_q       <= 1'b0;
                        data_q     <= '0;
                        state_q    <= FETCH;
                    end
                end

                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign oLUT_INDEX      = index_q;
    assign sccb.oSCCB_GO   = go_q;
    assign sccb.oSCCB_RD   = rd_q;
    assign sccb.oSCCB_DATA = data_q;
    assign oCONFIG_DONE    = done_q;
    assign oID_OK          = idOk_q;
    assign oERROR          = error_q;

endmodule
